// File: rtl/spi_master_if.sv
// Signal bundle between the SPI master, its control block and the SPI pins.
// The master modport is the engine side; the slave modport is the requester/pin side.
interface spi_master_if;
  logic [7:0] comp;
  logic       cpol;
  logic       cpha;
  logic [1:0] tr_en;
  logic       msb_lsb;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       tx_req;
  logic       tx_req_ack;
  logic       sck;
  logic       cs;
  logic       sdo;
  logic       sdi;

  modport master (
    input  comp, cpol, cpha, tr_en, msb_lsb, tx_data, tx_req, sdi,
    output rx_data, tx_req_ack, sck, cs, sdo
  );

  modport slave (
    output comp, cpol, cpha, tr_en, msb_lsb, tx_data, tx_req, sdi,
    input  rx_data, tx_req_ack, sck, cs, sdo
  );
endinterface

// File: rtl/spi_master.sv
// Single-frame (8-bit) SPI master: all four CPOL/CPHA modes, MSB/LSB-first,
// programmable SCK half-period of comp+1 clocks, level request / pulse acknowledge.
module spi_master (
  input  logic         clk,
  input  logic         resetn,
  spi_master_if.master bus
);
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, HOLD, DONE} state_t;

  state_t     state_q, state_d;
  logic [7:0] comp_q, comp_d;
  logic       cpha_q, cpha_d;
  logic       msb_lsb_q, msb_lsb_d;
  logic [1:0] tr_en_q, tr_en_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic [7:0] cnt_q, cnt_d;
  logic [4:0] edge_q, edge_d;
  logic       sck_q, sck_d;
  logic       cs_q, cs_d;
  logic       sdo_q, sdo_d;
  logic       ack_q, ack_d;

  logic [4:0] edge_nxt;
  logic       leading;
  logic       drive_edge;
  logic       sample_edge;

  function automatic logic first_bit(input logic [7:0] sh, input logic msb);
    return msb ? sh[7] : sh[0];
  endfunction

  function automatic logic [7:0] tx_shift(input logic [7:0] sh, input logic msb);
    return msb ? {sh[6:0], 1'b0} : {1'b0, sh[7:1]};
  endfunction

  function automatic logic [7:0] rx_shift(input logic [7:0] sh, input logic msb, input logic b);
    return msb ? {sh[6:0], b} : {b, sh[7:1]};
  endfunction

  always_comb begin
    edge_nxt    = edge_q + 5'd1;
    leading     = edge_nxt[0];
    // cpha=0 already put bit 0 out in LOAD, so only trailing edges 2..14 move data
    drive_edge  = cpha_q ? leading : (!leading && (edge_nxt <= 5'd14));
    sample_edge = cpha_q ? !leading : leading;

    state_d   = state_q;
    comp_d    = comp_q;
    cpha_d    = cpha_q;
    msb_lsb_d = msb_lsb_q;
    tr_en_d   = tr_en_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    cnt_d     = cnt_q;
    edge_d    = edge_q;
    sck_d     = sck_q;
    cs_d      = cs_q;
    sdo_d     = sdo_q;
    ack_d     = 1'b0;

    case (state_q)
      IDLE: begin
        cs_d  = 1'b1;
        sdo_d = 1'b0;
        sck_d = bus.cpol;
        if (bus.tx_req) begin
          comp_d    = bus.comp;
          cpha_d    = bus.cpha;
          msb_lsb_d = bus.msb_lsb;
          tr_en_d   = bus.tr_en;
          tx_sh_d   = bus.tx_data;
          state_d   = (bus.tr_en == 2'b00) ? DONE : LOAD;
        end
      end
      LOAD: begin
        cs_d    = 1'b0;
        cnt_d   = 8'd0;
        edge_d  = 5'd0;
        if (!cpha_q) begin
          sdo_d   = first_bit(tx_sh_q, msb_lsb_q) & tr_en_q[0];
          tx_sh_d = tx_shift(tx_sh_q, msb_lsb_q);
        end
        state_d = SHIFT;
      end
      SHIFT: begin
        if (cnt_q == comp_q) begin
          cnt_d  = 8'd0;
          sck_d  = ~sck_q;
          edge_d = edge_nxt;
          if (drive_edge) begin
            sdo_d   = first_bit(tx_sh_q, msb_lsb_q) & tr_en_q[0];
            tx_sh_d = tx_shift(tx_sh_q, msb_lsb_q);
          end
          if (sample_edge) rx_sh_d = rx_shift(rx_sh_q, msb_lsb_q, bus.sdi);
          if (edge_nxt == 5'd16) state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HOLD: begin
        if (cnt_q == comp_q) begin
          cs_d    = 1'b1;
          sdo_d   = 1'b0;
          ack_d   = 1'b1;
          if (tr_en_q[1]) rx_data_d = rx_sh_q;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        // A real frame raised ack on entry; an empty (tr_en=00) request acks one cycle later
        ack_d   = (tr_en_q == 2'b00);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    comp_q    <= comp_d;
    cpha_q    <= cpha_d;
    msb_lsb_q <= msb_lsb_d;
    tr_en_q   <= tr_en_d;
    tx_sh_q   <= tx_sh_d;
    rx_sh_q   <= rx_sh_d;
    if (resetn) begin
      state_q   <= IDLE;
      rx_data_q <= 8'd0;
      cnt_q     <= 8'd0;
      edge_q    <= 5'd0;
      sck_q     <= 1'b0;
      cs_q      <= 1'b1;
      sdo_q     <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_data_q <= rx_data_d;
      cnt_q     <= cnt_d;
      edge_q    <= edge_d;
      sck_q     <= sck_d;
      cs_q      <= cs_d;
      sdo_q     <= sdo_d;
      ack_q     <= ack_d;
    end
  end

  assign bus.sck        = sck_q;
  assign bus.cs         = cs_q;
  assign bus.sdo        = sdo_q;
  assign bus.tx_req_ack = ack_q;
  assign bus.rx_data    = rx_data_q;
endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: reset, modes 0/3, slow divider, empty request,
// mid-frame reset and a run of random back-to-back frames.
module tb_spi_master;
  logic clk = 1'b0;
  logic resetn;
  logic echo;
  logic slv_bit;
  logic [7:0] slv_pat;

  spi_master_if bus();

  spi_master dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.master)
  );

  always #5 clk = ~clk;

  assign bus.sdi = echo ? bus.sdo : slv_bit;

  int n_chk;
  int n_fail;

  int cyc = 0;
  int n_edges = 0;
  int frame_edges = 0;
  int last_edge = 0;
  int bad_gap = 0;
  int cs_falls = 0;
  int exp_gap = 1;
  int slv_idx = 0;
  logic [7:0] rise_log = 8'd0;
  logic sck_prev = 1'b0;
  logic cs_prev = 1'b1;

  // Pin monitor and mode-0 MSB-first slave, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (bus.cs === 1'b0 && cs_prev === 1'b1) begin
      cs_falls++;
      frame_edges = 0;
      slv_idx = 0;
      slv_bit = slv_pat[7];
    end else if (bus.cs === 1'b0 && bus.sck !== sck_prev) begin
      if (frame_edges > 0 && (cyc - last_edge) != exp_gap) bad_gap++;
      frame_edges++;
      n_edges++;
      last_edge = cyc;
      if (bus.sck === 1'b1) rise_log = {rise_log[6:0], bus.sdo};
      if (bus.sck === 1'b0 && slv_idx < 7) begin
        slv_idx++;
        slv_bit = slv_pat[7 - slv_idx];
      end
    end
    sck_prev = bus.sck;
    cs_prev  = bus.cs;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input logic cp, input logic ph, input logic ord,
                           input logic [7:0] cmp, input logic [1:0] en,
                           input logic [7:0] tx, input logic ec,
                           output int lat, output int acks,
                           output logic cs_at_ack, output logic sck_at_ack);
    bus.cpol    = cp;
    bus.cpha    = ph;
    bus.msb_lsb = ord;
    bus.comp    = cmp;
    bus.tr_en   = en;
    bus.tx_data = tx;
    echo        = ec;
    exp_gap     = int'(cmp) + 1;
    bus.tx_req  = 1'b1;
    lat  = 0;
    acks = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (bus.tx_req_ack !== 1'b1 && lat < 5000);
    bus.tx_req = 1'b0;
    if (bus.tx_req_ack === 1'b1) acks = 1;
    cs_at_ack  = bus.cs;
    sck_at_ack = bus.sck;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.tx_req_ack === 1'b1) acks++;
    end
  endtask

  int lat, acks, base_edges, base_gap, base_falls, w;
  logic cs_a, sck_a;
  logic r_cp, r_ph, r_ord;
  logic [7:0] r_cmp, r_tx;
  logic [7:0] comp_tab [10];

  initial begin
    n_chk = 0;
    n_fail = 0;
    comp_tab = '{8'd0, 8'd1, 8'd2, 8'd4, 8'd8, 8'd16, 8'd32, 8'd64, 8'd128, 8'd255};
    resetn      = 1'b1;
    bus.tx_req  = 1'b0;
    bus.cpol    = 1'b0;
    bus.cpha    = 1'b0;
    bus.tr_en   = 2'b11;
    bus.msb_lsb = 1'b1;
    bus.comp    = 8'd0;
    bus.tx_data = 8'd0;
    echo        = 1'b1;
    slv_bit     = 1'b0;
    slv_pat     = 8'd0;

    // Reset held for 7 cycles
    repeat (7) @(posedge clk);
    #1;
    chk("rst_cs", 32'(bus.cs), 32'd1);
    chk("rst_sck", 32'(bus.sck), 32'd0);
    chk("rst_sdo", 32'(bus.sdo), 32'd0);
    chk("rst_rx", 32'(bus.rx_data), 32'h00);
    chk("rst_ack", 32'(bus.tx_req_ack), 32'd0);
    bus.cpol = 1'b1;
    resetn   = 1'b0;
    @(posedge clk); #1;
    chk("idle_sck_cpol", 32'(bus.sck), 32'd1);
    chk("idle_cs", 32'(bus.cs), 32'd1);

    // Mode 0, MSB first, slave returns 0x3C
    slv_pat = 8'h3C;
    base_edges = n_edges;
    base_gap = bad_gap;
    run_frame(1'b0, 1'b0, 1'b1, 8'd0, 2'b11, 8'hA5, 1'b0, lat, acks, cs_a, sck_a);
    chk("m0_lat", 32'(lat), 32'd19);
    chk("m0_acks", 32'(acks), 32'd1);
    chk("m0_rx", 32'(bus.rx_data), 32'h3C);
    chk("m0_sdo_bits", 32'(rise_log), 32'hA5);
    chk("m0_edges", 32'(n_edges - base_edges), 32'd16);
    chk("m0_gap", 32'(bad_gap - base_gap), 32'd0);
    chk("m0_cs_at_ack", 32'(cs_a), 32'd1);
    chk("m0_sck_at_ack", 32'(sck_a), 32'd0);

    // Mode 3, LSB first, comp=4, echo
    base_edges = n_edges;
    base_gap = bad_gap;
    run_frame(1'b1, 1'b1, 1'b0, 8'd4, 2'b11, 8'h81, 1'b1, lat, acks, cs_a, sck_a);
    chk("m3_lat", 32'(lat), 32'd87);
    chk("m3_acks", 32'(acks), 32'd1);
    chk("m3_rx", 32'(bus.rx_data), 32'h81);
    chk("m3_sdo_bits", 32'(rise_log), 32'h81);
    chk("m3_edges", 32'(n_edges - base_edges), 32'd16);
    chk("m3_gap", 32'(bad_gap - base_gap), 32'd0);
    chk("m3_cs_at_ack", 32'(cs_a), 32'd1);
    chk("m3_sck_at_ack", 32'(sck_a), 32'd1);

    // Preload 0x5A, then a transmit-only frame at comp=255
    run_frame(1'b0, 1'b0, 1'b1, 8'd0, 2'b11, 8'h5A, 1'b1, lat, acks, cs_a, sck_a);
    chk("pre_rx", 32'(bus.rx_data), 32'h5A);
    base_edges = n_edges;
    base_gap = bad_gap;
    run_frame(1'b0, 1'b1, 1'b1, 8'd255, 2'b01, 8'hFF, 1'b1, lat, acks, cs_a, sck_a);
    chk("slow_lat", 32'(lat), 32'd4354);
    chk("slow_acks", 32'(acks), 32'd1);
    chk("slow_rx_hold", 32'(bus.rx_data), 32'h5A);
    chk("slow_edges", 32'(n_edges - base_edges), 32'd16);
    chk("slow_gap", 32'(bad_gap - base_gap), 32'd0);

    // Empty request: tr_en=00
    base_edges = n_edges;
    base_falls = cs_falls;
    run_frame(1'b0, 1'b0, 1'b1, 8'd3, 2'b00, 8'hFF, 1'b1, lat, acks, cs_a, sck_a);
    chk("none_lat", 32'(lat), 32'd2);
    chk("none_acks", 32'(acks), 32'd1);
    chk("none_rx", 32'(bus.rx_data), 32'h5A);
    chk("none_edges", 32'(n_edges - base_edges), 32'd0);
    chk("none_cs_falls", 32'(cs_falls - base_falls), 32'd0);

    // Reset at edge 7 of a mode-1 frame
    bus.cpol = 1'b0; bus.cpha = 1'b1; bus.msb_lsb = 1'b1; bus.comp = 8'd1;
    bus.tr_en = 2'b11; bus.tx_data = 8'h33; echo = 1'b1; exp_gap = 2;
    base_edges = n_edges;
    bus.tx_req = 1'b1;
    w = 0;
    do begin
      @(posedge clk); #1;
      w++;
    end while ((n_edges - base_edges) < 7 && w < 1000);
    chk("abort_edge7", 32'(n_edges - base_edges), 32'd7);
    chk("abort_sck_before", 32'(bus.sck), 32'd1);
    resetn = 1'b1;
    bus.tx_req = 1'b0;
    @(posedge clk); #1;
    chk("abort_cs", 32'(bus.cs), 32'd1);
    chk("abort_sck", 32'(bus.sck), 32'd0);
    chk("abort_ack", 32'(bus.tx_req_ack), 32'd0);
    chk("abort_rx", 32'(bus.rx_data), 32'h00);
    resetn = 1'b0;
    acks = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.tx_req_ack === 1'b1) acks++;
    end
    chk("abort_no_ack", 32'(acks), 32'd0);
    run_frame(1'b1, 1'b0, 1'b0, 8'd2, 2'b11, 8'hC6, 1'b1, lat, acks, cs_a, sck_a);
    chk("post_lat", 32'(lat), 32'd53);
    chk("post_acks", 32'(acks), 32'd1);
    chk("post_rx", 32'(bus.rx_data), 32'hC6);

    // Random back-to-back frames, echo loopback
    for (int i = 0; i < 10; i++) begin
      r_cp  = 1'($urandom_range(0, 1));
      r_ph  = 1'($urandom_range(0, 1));
      r_ord = 1'($urandom_range(0, 1));
      r_cmp = comp_tab[$urandom_range(0, 9)];
      r_tx  = 8'($urandom);
      run_frame(r_cp, r_ph, r_ord, r_cmp, 2'b11, r_tx, 1'b1, lat, acks, cs_a, sck_a);
      chk("rnd_lat", 32'(lat), 32'(2 + 17 * (int'(r_cmp) + 1)));
      chk("rnd_acks", 32'(acks), 32'd1);
      chk("rnd_rx", 32'(bus.rx_data), 32'(r_tx));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
Single-channel SPI master that shifts one 8-bit frame per request. It supports all four CPOL/CPHA modes, MSB- or LSB-first ordering and a programmable SCK divider. It sits between a register/control block (level request, one-cycle acknowledge) and the external SPI pins (sck, cs, sdo, sdi).

Parameters:
none (frame width fixed at 8 bits)

Ports:
clk  in  1  system clock, all logic on rising edge
resetn  in  1  synchronous reset, active-high (asserted = 1 despite the codebase name)
comp  in  8  SCK divider; each SCK half-period lasts comp+1 clk cycles
cpol  in  1  SCK idle level
cpha  in  1  0 = sample on leading edge; 1 = sample on trailing edge
tr_en  in  2  bit0 = transmit enable (drive sdo); bit1 = receive enable (update rx_data)
msb_lsb  in  1  1 = MSB first, 0 = LSB first
tx_data  in  8  frame to transmit
rx_data  out  8  last received frame (registered)
tx_req  in  1  level request; sampled only in IDLE
tx_req_ack  out  1  one-cycle pulse at end of frame
sck  out  1  SPI clock
cs  out  1  chip select, active low
sdo  out  1  serial data out
sdi  in  1  serial data in

Behaviour:
- Reset values: rx_data=0, tx_req_ack=0, sck=0, cs=1, sdo=0; FSM=IDLE. Reset mid-frame aborts immediately, no ack.
- States: IDLE -> LOAD -> SHIFT -> HOLD -> DONE -> IDLE.
- IDLE: cs=1, sdo=0, sck registered from cpol every cycle. If tx_req=1, latch comp, cpol, cpha, tr_en, msb_lsb, tx_data and go to LOAD. Input changes during a frame are ignored.
- tr_en=2'b00 with tx_req=1: go straight to DONE (no cs/sck activity, rx_data unchanged); ack pulses 1 cycle later.
- LOAD (1 cycle): cs<=0, divider counter<=0. For cpha=0 the first bit is driven on sdo here.
- SHIFT: counter counts 0..comp. When it reaches comp, toggle sck and clear counter, giving 16 edges per frame.
  - Leading edges are odd (1,3,..15); trailing edges are even (2,..16).
  - cpha=0: sample sdi on leading edges; shift the next bit out on trailing edges 2..14.
  - cpha=1: shift a bit out on leading edges; sample sdi on trailing edges.
- Bit order: msb_lsb=1 sends tx bit7 first and fills rx from bit7 downward; msb_lsb=0 sends bit0 first and fills rx from bit0 upward.
- sdo is 0 throughout when latched tr_en[0]=0.
- After edge 16, sck is back at cpol.
- HOLD: one extra half-period (comp+1 cycles) with cs low.
- DONE (1 cycle): cs<=1, tx_req_ack<=1 for exactly one cycle. rx_data updates in the same cycle only if latched tr_en[1]=1, otherwise it holds.
- Next cycle is IDLE, which re-samples tx_req. A requester that drops tx_req on seeing ack is never double-served; if tx_req is still high, a new frame starts.
- Latency (tr_en≠0): from the IDLE cycle sampling tx_req=1 to the ack-high cycle is 2 + 17*(comp+1) clk cycles. comp=0 gives 19; comp=255 gives 4354.
- sck, cs, sdo and tx_req_ack are all registered outputs with no combinational paths from inputs.

Test Plan:
- Reset held 7 cycles: cs=1, sck=0, sdo=0, rx_data=0, ack=0; release → IDLE, sck follows cpol.
- Mode 0, msb_lsb=1, comp=0, tx_data=0xA5, sdi returns 0x3C: sdo shows 1,0,1,0,0,1,0,1; rx_data=0x3C; ack high 1 cycle, 19 cycles after request.
- Mode 3, msb_lsb=0, comp=4, tx_data=0x81, sdi echo of sdo: sck idles 1 with half-period 5 clks; data changes on falling edges; rx_data=0x81; cs high at ack.
- comp=255, tr_en=2'b01, rx_data preloaded 0x5A: 16 sck edges each 256 clks apart; rx_data stays 0x5A; ack after 4354 cycles.
- tr_en=2'b00 with tx_req=1: no cs/sck toggling; ack after 2 cycles; rx_data unchanged.
- Assert resetn at edge 7 of a frame: next cycle cs=1, sck=0, no ack; a subsequent request completes normally. Also run 10 back-to-back random frames (random mode, order, comp in {0,1,2,4,…,128,255}), dropping tx_req on ack: exactly one ack per request.
